// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ clients.
// Frame end is inferred by counting bit_tick strobes because tx has no done flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 7,
  parameter int STOP_BITS = 1,
  parameter int GAP_TICKS = 0,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  input  logic                           bit_tick,
  output logic                           tx_pl,
  output logic [DATA_SIZE-1:0]           tx_d,
  output logic                           busy,
  output logic [ID_W-1:0]                gnt_id
);

  localparam int FRAME_BITS = 1 + DATA_SIZE + STOP_BITS;
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   pl_q, pl_d;
  logic [DATA_SIZE-1:0]   txd_q, txd_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [ID_W-1:0]        last_q, last_d;

  logic                   win_vld;
  logic [ID_W-1:0]        win;
  logic [DATA_SIZE-1:0]   win_data;

  // Scan starts one past the last winner so every active requester gets a turn.
  always_comb begin
    win_vld  = 1'b0;
    win      = '0;
    win_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_vld && req[idx]) begin
        win_vld  = 1'b1;
        win      = ID_W'(idx);
        win_data = req_data[idx*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    pl_d    = 1'b0;
    txd_d   = txd_q;
    gid_d   = gid_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: if (win_vld) begin
        grant_d[win] = 1'b1;
        txd_d        = win_data;
        gid_d        = win;
        last_d       = win;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        pl_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: if (bit_tick) begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_GAP: if (bit_tick) begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_q resets to the top index so requester 0 is scanned first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      pl_q    <= 1'b0;
      txd_q   <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pl_q    <= pl_d;
      txd_q   <= txd_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  assign grant  = grant_q;
  assign tx_pl  = pl_q;
  assign tx_d   = txd_q;
  assign gnt_id = gid_q;
  assign busy   = (state_q != S_IDLE);

endmodule
